// File: rtl/lvl_state_ctrl.sv
// Sequencer for the per-level state list: bulk load from bin memory, bulk store
// to bin memory, and find-and-apply of the backtrack level.
module lvl_state_ctrl #(
    parameter int NUM_LVL          = 32,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_ADDR       = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_load_i,
    input  logic                                  start_store_i,
    input  logic                                  start_find_i,
    input  logic [WIDTH_ADDR-1:0]                 mem_base_i,
    input  logic [WIDTH_LVL-1:0]                  max_lvl_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [WIDTH_BIN_ID-1:0]               bkt_bin_o,
    output logic [WIDTH_LVL-1:0]                  bkt_lvl_o,
    output logic                                  bkt_none_o,
    output logic [WIDTH_ADDR-1:0]                 mem_addr_o,
    output logic                                  mem_rd_o,
    output logic                                  mem_wr_o,
    output logic [WIDTH_LVL_STATES-1:0]           mem_wdata_o,
    input  logic [WIDTH_LVL_STATES-1:0]           mem_rdata_i,
    output logic [NUM_LVL-1:0]                    ls_wr_o,
    output logic [WIDTH_LVL_STATES-1:0]           ls_wdata_o,
    input  logic [NUM_LVL*WIDTH_LVL_STATES-1:0]   ls_rdata_i,
    output logic [WIDTH_LVL-1:0]                  ls_max_lvl_o,
    input  logic [WIDTH_BIN_ID-1:0]               ls_bkt_bin_i,
    input  logic [WIDTH_LVL-1:0]                  ls_bkt_lvl_i,
    output logic                                  ls_apply_bkt_o
);

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_LAST, STORE, FIND_DRV, FIND_CAP, APPLY, DONE
    } state_t;

    localparam int IW = (NUM_LVL > 1) ? $clog2(NUM_LVL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_LVL - 1);

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx;
    logic [WIDTH_ADDR-1:0]   base;
    logic [WIDTH_LVL-1:0]    max_lvl;
    logic [WIDTH_ADDR-1:0]   addr;
    logic                    accept;

    assign accept = (state == IDLE) && (start_load_i || start_store_i || start_find_i);
    // Address wraps silently modulo 2^WIDTH_ADDR.
    assign addr   = base + WIDTH_ADDR'(idx);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_load_i)       state_nxt = LOAD;
                else if (start_store_i) state_nxt = STORE;
                else if (start_find_i)  state_nxt = FIND_DRV;
            end
            LOAD:      if (idx == LAST) state_nxt = LOAD_LAST;
            LOAD_LAST: state_nxt = DONE;
            STORE:     if (idx == LAST) state_nxt = DONE;
            FIND_DRV:  state_nxt = FIND_CAP;
            FIND_CAP:  state_nxt = (ls_bkt_lvl_i == '0) ? DONE : APPLY;
            APPLY:     state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= '0;
            base       <= '0;
            max_lvl    <= '0;
            bkt_bin_o  <= '0;
            bkt_lvl_o  <= '0;
            bkt_none_o <= 1'b0;
        end else begin
            if (accept) begin
                base    <= mem_base_i;
                max_lvl <= max_lvl_i;
                idx     <= '0;
            end else if ((state == LOAD || state == STORE) && idx != LAST) begin
                idx <= idx + 1'b1;
            end
            // Cell bkt outputs were registered on the FIND_DRV edge; sample them here.
            if (state == FIND_CAP) begin
                bkt_bin_o  <= ls_bkt_bin_i;
                bkt_lvl_o  <= ls_bkt_lvl_i;
                bkt_none_o <= (ls_bkt_lvl_i == '0);
            end
        end
    end

    always_comb begin
        busy_o         = 1'b0;
        done_o         = 1'b0;
        mem_addr_o     = '0;
        mem_rd_o       = 1'b0;
        mem_wr_o       = 1'b0;
        mem_wdata_o    = '0;
        ls_wr_o        = '0;
        ls_wdata_o     = '0;
        ls_max_lvl_o   = '0;
        ls_apply_bkt_o = 1'b0;
        case (state)
            LOAD: begin
                busy_o     = 1'b1;
                mem_rd_o   = 1'b1;
                mem_addr_o = addr;
                // Read data lags the address by one cycle, so cell idx-1 is written now.
                if (idx != '0) begin
                    ls_wr_o    = NUM_LVL'(1) << (idx - 1'b1);
                    ls_wdata_o = mem_rdata_i;
                end
            end
            LOAD_LAST: begin
                busy_o               = 1'b1;
                ls_wr_o[NUM_LVL-1]   = 1'b1;
                ls_wdata_o           = mem_rdata_i;
            end
            STORE: begin
                busy_o      = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = addr;
                mem_wdata_o = ls_rdata_i[idx*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
            end
            FIND_DRV, FIND_CAP: begin
                busy_o       = 1'b1;
                ls_max_lvl_o = max_lvl;
            end
            APPLY: begin
                busy_o         = 1'b1;
                ls_max_lvl_o   = max_lvl;
                ls_apply_bkt_o = 1'b1;
            end
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lvl_state_ctrl.sv
// Directed bench for lvl_state_ctrl with a four-cell list and a small ROM model.
module tb_lvl_state_ctrl;
    localparam int N = 4, W = 11, WL = 16, WB = 10, WA = 12;

    logic clk = 1'b0;
    logic rst;
    logic start_load_i, start_store_i, start_find_i;
    logic [WA-1:0] mem_base_i;
    logic [WL-1:0] max_lvl_i;
    logic busy_o, done_o, bkt_none_o;
    logic [WB-1:0] bkt_bin_o;
    logic [WL-1:0] bkt_lvl_o;
    logic [WA-1:0] mem_addr_o;
    logic mem_rd_o, mem_wr_o;
    logic [W-1:0] mem_wdata_o, mem_rdata_i;
    logic [N-1:0] ls_wr_o;
    logic [W-1:0] ls_wdata_o;
    logic [N*W-1:0] ls_rdata_i;
    logic [WL-1:0] ls_max_lvl_o;
    logic [WB-1:0] ls_bkt_bin_i;
    logic [WL-1:0] ls_bkt_lvl_i;
    logic ls_apply_bkt_o;

    int checks = 0;
    int errors = 0;

    lvl_state_ctrl #(.NUM_LVL(N), .WIDTH_LVL_STATES(W), .WIDTH_LVL(WL),
                     .WIDTH_BIN_ID(WB), .WIDTH_ADDR(WA)) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_store_i(start_store_i), .start_find_i(start_find_i),
        .mem_base_i(mem_base_i), .max_lvl_i(max_lvl_i),
        .busy_o(busy_o), .done_o(done_o),
        .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o), .bkt_none_o(bkt_none_o),
        .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .ls_wr_o(ls_wr_o), .ls_wdata_o(ls_wdata_o), .ls_rdata_i(ls_rdata_i),
        .ls_max_lvl_o(ls_max_lvl_o), .ls_bkt_bin_i(ls_bkt_bin_i), .ls_bkt_lvl_i(ls_bkt_lvl_i),
        .ls_apply_bkt_o(ls_apply_bkt_o)
    );

    always #5 clk = ~clk;

    // Bin memory: fixed contents at 0x010..0x013, read latency one cycle.
    function automatic logic [W-1:0] rom(input logic [WA-1:0] a);
        case (a)
            12'h010: rom = 11'h005;
            12'h011: rom = 11'h00A;
            12'h012: rom = 11'h00F;
            12'h013: rom = 11'h014;
            default: rom = 11'h7FF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= rom(mem_addr_o);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] io_v(input logic rd, input logic wr, input logic [WA-1:0] a,
                                         input logic [N-1:0] lw, input logic [W-1:0] wd,
                                         input logic dn, input logic bz);
        io_v = {33'd0, rd, wr, a, lw, wd, dn, bz};
    endfunction

    function automatic logic [63:0] io_act();
        io_act = io_v(mem_rd_o, mem_wr_o, mem_addr_o, ls_wr_o,
                      mem_wr_o ? mem_wdata_o : ls_wdata_o, done_o, busy_o);
    endfunction

    function automatic logic [63:0] fnd_act();
        fnd_act = {26'd0, ls_max_lvl_o, ls_apply_bkt_o, busy_o, done_o, bkt_bin_o, bkt_lvl_o, bkt_none_o};
    endfunction

    function automatic logic [63:0] fnd_v(input logic [WL-1:0] ml, input logic ap, input logic bz,
                                          input logic dn, input logic [WB-1:0] bb,
                                          input logic [WL-1:0] bl, input logic bn);
        fnd_v = {26'd0, ml, ap, bz, dn, bb, bl, bn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load from 0x010; optionally also raise find at accept and pulse store mid-load.
    task automatic run_load(input string tag, input logic with_find, input logic with_store,
                            input logic [WB-1:0] bb, input logic [WL-1:0] bl, input logic bn);
        logic [W-1:0]  ldv [4] = '{11'h005, 11'h00A, 11'h00F, 11'h014};
        logic [N-1:0]  lw;
        logic [W-1:0]  wd;
        mem_base_i   = 12'h010;
        start_load_i = 1'b1;
        start_find_i = with_find;
        tick();
        start_load_i = 1'b0;
        start_find_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            lw = (c == 0) ? 4'b0000 : (4'b0001 << (c - 1));
            wd = (c == 0) ? 11'h000 : ldv[c-1];
            chk($sformatf("%s_c%0d", tag, c), io_act(), io_v(1'b1, 1'b0, 12'h010 + 12'(c), lw, wd, 1'b0, 1'b1));
            chk($sformatf("%s_nofind_c%0d", tag, c), {62'd0, ls_apply_bkt_o, |ls_max_lvl_o}, 64'd0);
            if (with_store) start_store_i = (c == 1);
            tick();
        end
        start_store_i = 1'b0;
        chk({tag, "_last"}, io_act(), io_v(1'b0, 1'b0, 12'h000, 4'b1000, 11'h014, 1'b0, 1'b1));
        tick();
        chk({tag, "_done"}, io_act(), io_v(1'b0, 1'b0, 12'h000, 4'b0000, 11'h000, 1'b1, 1'b0));
        chk({tag, "_bkt_hold"}, {37'd0, bkt_bin_o, bkt_lvl_o, bkt_none_o}, {37'd0, bb, bl, bn});
        tick();
        chk({tag, "_idle"}, io_act(), 64'd0);
    endtask

    task automatic run_find(input string tag, input logic [WL-1:0] ml,
                            input logic [WL-1:0] bl, input logic [WB-1:0] bb,
                            input logic [WB-1:0] pbb, input logic [WL-1:0] pbl, input logic pbn);
        max_lvl_i    = ml;
        ls_bkt_lvl_i = bl;
        ls_bkt_bin_i = bb;
        start_find_i = 1'b1;
        tick();
        start_find_i = 1'b0;
        chk({tag, "_drv"}, fnd_act(), fnd_v(ml, 1'b0, 1'b1, 1'b0, pbb, pbl, pbn));
        tick();
        chk({tag, "_cap"}, fnd_act(), fnd_v(ml, 1'b0, 1'b1, 1'b0, pbb, pbl, pbn));
        tick();
        if (bl != 0) begin
            chk({tag, "_apply"}, fnd_act(), fnd_v(ml, 1'b1, 1'b1, 1'b0, bb, bl, 1'b0));
            tick();
        end
        chk({tag, "_done"}, fnd_act(), fnd_v('0, 1'b0, 1'b0, 1'b1, bb, bl, bl == 0));
        tick();
        chk({tag, "_idle"}, fnd_act(), fnd_v('0, 1'b0, 1'b0, 1'b0, bb, bl, bl == 0));
        chk({tag, "_mem_quiet"}, io_act(), 64'd0);
    endtask

    initial begin
        logic [WA-1:0] sa [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        rst = 1'b0;
        start_load_i = 1'b0; start_store_i = 1'b0; start_find_i = 1'b0;
        mem_base_i = '0; max_lvl_i = '0;
        ls_rdata_i = {11'h006, 11'h005, 11'h004, 11'h003};
        ls_bkt_bin_i = '0; ls_bkt_lvl_i = '0;
        tick(); tick();
        chk("reset_io", io_act(), 64'd0);
        chk("reset_find", fnd_act(), 64'd0);
        rst = 1'b1;
        tick();

        run_load("load", 1'b0, 1'b0, '0, '0, 1'b0);

        // Store across the address wrap; a find raised during DONE must be ignored.
        mem_base_i    = 12'hFFE;
        start_store_i = 1'b1;
        tick();
        start_store_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("store_c%0d", c), io_act(),
                io_v(1'b0, 1'b1, sa[c], 4'b0000, 11'h003 + 11'(c), 1'b0, 1'b1));
            tick();
        end
        chk("store_done", io_act(), io_v(1'b0, 1'b0, 12'h000, 4'b0000, 11'h000, 1'b1, 1'b0));
        start_find_i = 1'b1;
        tick();
        start_find_i = 1'b0;
        chk("store_done_start_ignored", fnd_act(), 64'd0);
        tick();
        chk("store_idle", {63'd0, busy_o}, 64'd0);

        run_find("find_hit", 16'd3, 16'd2, 10'd7, '0, '0, 1'b0);
        run_find("find_none", 16'd5, 16'd0, 10'h055, 10'd7, 16'd2, 1'b0);

        // Load wins over find; a store pulse mid-load is dropped; bkt results untouched.
        run_load("load_prio", 1'b1, 1'b1, 10'h055, 16'd0, 1'b1);
        chk("prio_no_store_after", io_act(), 64'd0);

        // Reset in the middle of a load at i=2.
        mem_base_i   = 12'h010;
        start_load_i = 1'b1;
        tick();
        start_load_i = 1'b0;
        tick(); tick();
        chk("pre_reset_i2", io_act(), io_v(1'b1, 1'b0, 12'h012, 4'b0010, 11'h00A, 1'b0, 1'b1));
        rst = 1'b0;
        tick();
        chk("midreset_io", io_act(), 64'd0);
        chk("midreset_find", fnd_act(), 64'd0);
        rst = 1'b1;
        tick();
        chk("post_reset_idle", io_act(), 64'd0);
        run_load("load_after_rst", 1'b0, 1'b0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
